// File: rtl/riscv_base_div_seq_pkg.sv
// riscv_base_div_seq_pkg: FSM encoding, id width and opcode field positions for the divider sequencer
package riscv_base_div_seq_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_e;
  localparam int ID_W = 1;
  localparam int REG_W = 5;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
endpackage

// File: rtl/riscv_base_rr_arb2.sv
// riscv_base_rr_arb2: two-way round-robin arbiter, ties go to the requester not granted last
module riscv_base_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] valid_i,
  input  logic       en_i,
  input  logic       update_i,
  output logic [1:0] grant_o
);
  logic last_q, last_d;
  always_comb begin
    grant_o = !en_i ? 2'b00 : (&valid_i) ? (last_q ? 2'b01 : 2'b10) : valid_i;
    last_d = (update_i && |grant_o) ? grant_o[1] : last_q;
  end
  always_ff @(posedge clk_i) last_q <= rst_i ? 1'b1 : last_d;
endmodule

// File: rtl/riscv_base_div_sequencer.sv
// riscv_base_div_sequencer: arbitrates two requesters onto one iterative divider and returns tagged results
module riscv_base_div_sequencer
  import riscv_base_div_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int TMR_W = 6
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  req_valid_i,
  output logic [1:0]  req_ready_o,
  input  logic [63:0] req_opcode_i,
  input  logic [63:0] req_pc_i,
  input  logic [9:0]  req_rd_idx_i,
  input  logic [63:0] req_ra_operand_i,
  input  logic [63:0] req_rb_operand_i,
  input  logic [1:0]  flush_i,
  output logic        div_valid_o,
  output logic [31:0] div_opcode_o,
  output logic [31:0] div_pc_o,
  output logic        div_invalid_o,
  output logic [4:0]  div_rd_idx_o,
  output logic [4:0]  div_ra_idx_o,
  output logic [4:0]  div_rb_idx_o,
  output logic [31:0] div_ra_operand_o,
  output logic [31:0] div_rb_operand_o,
  input  logic        div_wb_valid_i,
  input  logic [31:0] div_wb_value_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic        resp_id_o,
  output logic [4:0]  resp_rd_idx_o,
  output logic [31:0] resp_value_o,
  output logic        resp_timeout_o,
  output logic        busy_o
);
  state_e state_q, state_d;
  logic [31:0] opcode_q, opcode_d, pc_q, pc_d, ra_q, ra_d, rb_q, rb_d, value_q, value_d;
  logic [REG_W-1:0] rd_q, rd_d;
  logic [ID_W-1:0] id_q, id_d;
  logic kill_q, kill_d, timeout_q, timeout_d, kill_now, done;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [1:0] grant;
  riscv_base_rr_arb2 u_arb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (req_valid_i & ~flush_i),
    .en_i     (state_q == ST_IDLE),
    .update_i (|grant),
    .grant_o  (grant)
  );
  assign req_ready_o = grant;
  assign div_valid_o = state_q == ST_ISSUE;
  assign div_opcode_o = opcode_q;
  assign div_pc_o = pc_q;
  assign div_invalid_o = 1'b0;
  assign div_rd_idx_o = rd_q;
  assign div_ra_idx_o = opcode_q[RS1_LSB +: REG_W];
  assign div_rb_idx_o = opcode_q[RS2_LSB +: REG_W];
  assign div_ra_operand_o = ra_q;
  assign div_rb_operand_o = rb_q;
  assign resp_valid_o = state_q == ST_RESP;
  assign resp_id_o = id_q;
  assign resp_rd_idx_o = rd_q;
  assign resp_value_o = value_q;
  assign resp_timeout_o = timeout_q;
  assign busy_o = state_q != ST_IDLE;
  always_comb begin
    state_d = state_q;
    opcode_d = opcode_q;
    pc_d = pc_q;
    rd_d = rd_q;
    ra_d = ra_q;
    rb_d = rb_q;
    id_d = id_q;
    kill_d = kill_q;
    tmr_d = tmr_q;
    value_d = value_q;
    timeout_d = timeout_q;
    kill_now = kill_q | flush_i[id_q];
    done = div_wb_valid_i || tmr_q == TMR_W'(TIMEOUT_CYCLES - 1);
    case (state_q)
      ST_IDLE: if (|grant) begin
        state_d = ST_ISSUE;
        opcode_d = grant[1] ? req_opcode_i[63:32] : req_opcode_i[31:0];
        pc_d = grant[1] ? req_pc_i[63:32] : req_pc_i[31:0];
        rd_d = grant[1] ? req_rd_idx_i[9:5] : req_rd_idx_i[4:0];
        ra_d = grant[1] ? req_ra_operand_i[63:32] : req_ra_operand_i[31:0];
        rb_d = grant[1] ? req_rb_operand_i[63:32] : req_rb_operand_i[31:0];
        id_d = grant[1];
        kill_d = 1'b0;
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        tmr_d = '0;
        kill_d = kill_now;
      end
      ST_WAIT: begin
        tmr_d = tmr_q + 1'b1;
        kill_d = kill_now;
        if (done) begin
          state_d = kill_now ? ST_IDLE : ST_RESP;
          value_d = kill_now ? value_q : div_wb_valid_i ? div_wb_value_i : '0;
          timeout_d = kill_now ? timeout_q : !div_wb_valid_i;
        end
      end
      default: state_d = (flush_i[id_q] || resp_ready_i) ? ST_IDLE : ST_RESP;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      opcode_q <= '0;
      pc_q <= '0;
      rd_q <= '0;
      ra_q <= '0;
      rb_q <= '0;
      id_q <= '0;
      kill_q <= 1'b0;
      tmr_q <= '0;
      value_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      opcode_q <= opcode_d;
      pc_q <= pc_d;
      rd_q <= rd_d;
      ra_q <= ra_d;
      rb_q <= rb_d;
      id_q <= id_d;
      kill_q <= kill_d;
      tmr_q <= tmr_d;
      value_q <= value_d;
      timeout_q <= timeout_d;
    end
  end
endmodule

// File: tb/tb_riscv_base_div_sequencer.sv
// tb_riscv_base_div_sequencer: randomized and directed checks of the divider sequencer against a reference model
module tb_riscv_base_div_sequencer;
  localparam int TO = 40;
  logic clk_i = 1'b0, rst_i;
  logic [1:0] req_valid_i, req_ready_o, flush_i;
  logic [63:0] req_opcode_i, req_pc_i, req_ra_operand_i, req_rb_operand_i;
  logic [9:0] req_rd_idx_i;
  logic div_valid_o, div_invalid_o, div_wb_valid_i;
  logic [31:0] div_opcode_o, div_pc_o, div_ra_operand_o, div_rb_operand_o, div_wb_value_i;
  logic [4:0] div_rd_idx_o, div_ra_idx_o, div_rb_idx_o, resp_rd_idx_o;
  logic resp_valid_o, resp_ready_i, resp_id_o, resp_timeout_o, busy_o;
  logic [31:0] resp_value_o;
  int n_tests = 0, n_fail = 0;
  logic tb_last;
  logic [31:0] ops[2], pcs[2], as[2], bs[2];
  logic [4:0] rds[2];
  always #5 clk_i = ~clk_i;
  riscv_base_div_sequencer dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_opcode_i(req_opcode_i), .req_pc_i(req_pc_i), .req_rd_idx_i(req_rd_idx_i),
    .req_ra_operand_i(req_ra_operand_i), .req_rb_operand_i(req_rb_operand_i), .flush_i(flush_i),
    .div_valid_o(div_valid_o), .div_opcode_o(div_opcode_o), .div_pc_o(div_pc_o),
    .div_invalid_o(div_invalid_o), .div_rd_idx_o(div_rd_idx_o), .div_ra_idx_o(div_ra_idx_o),
    .div_rb_idx_o(div_rb_idx_o), .div_ra_operand_o(div_ra_operand_o), .div_rb_operand_o(div_rb_operand_o),
    .div_wb_valid_i(div_wb_valid_i), .div_wb_value_i(div_wb_value_i), .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready_i), .resp_id_o(resp_id_o), .resp_rd_idx_o(resp_rd_idx_o),
    .resp_value_o(resp_value_o), .resp_timeout_o(resp_timeout_o), .busy_o(busy_o)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(negedge clk_i);
  endtask
  function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, q;
    sa = a;
    sb = b;
    if (b == 32'h0) return f3[1] ? a : 32'hFFFFFFFF;
    if (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return f3[1] ? 32'h0 : a;
    case (f3)
      3'b100: begin q = sa / sb; return q; end
      3'b110: begin q = sa % sb; return q; end
      3'b101: return a / b;
      default: return a % b;
    endcase
  endfunction
  function automatic logic [31:0] mk_op(input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0000001, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  task automatic set_req(input int n, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    ops[n] = mk_op(f3, rd, 5'($urandom), 5'($urandom));
    pcs[n] = $urandom & 32'hFFFFFFFC;
    as[n] = a;
    bs[n] = b;
    rds[n] = rd;
  endtask
  task automatic do_reset();
    rst_i = 1'b1;
    req_valid_i = '0;
    flush_i = '0;
    div_wb_valid_i = 1'b0;
    div_wb_value_i = '0;
    resp_ready_i = 1'b0;
    repeat (2) cyc();
    #1;
    rst_i = 1'b0;
    tb_last = 1'b1;
  endtask
  // mode: 0 normal, 1 flush own in WAIT, 2 divider silent, 3 flush own in RESP, 4 flush other in WAIT
  task automatic run_txn(input logic [1:0] vm, input int lat, input int bp, input int mode);
    logic w;
    logic [31:0] exp_v;
    w = (vm == 2'b11) ? !tb_last : vm[1];
    exp_v = (mode == 2) ? 32'h0 : ref_div(ops[w][14:12], as[w], bs[w]);
    cyc();
    req_valid_i = vm;
    req_opcode_i = {ops[1], ops[0]};
    req_pc_i = {pcs[1], pcs[0]};
    req_rd_idx_i = {rds[1], rds[0]};
    req_ra_operand_i = {as[1], as[0]};
    req_rb_operand_i = {bs[1], bs[0]};
    #1;
    chk("req_ready", req_ready_o, w ? 2'b10 : 2'b01);
    tb_last = w;
    cyc();
    req_valid_i = '0;
    #1;
    chk("issue_pulse", div_valid_o, 1);
    chk("issue_fields", {div_rd_idx_o, div_invalid_o, busy_o}, {rds[w], 2'b01});
    chk("issue_idx", {div_ra_idx_o, div_rb_idx_o}, {ops[w][19:15], ops[w][24:20]});
    chk("issue_opcode", div_opcode_o, ops[w]);
    chk("issue_pc", div_pc_o, pcs[w]);
    chk("issue_ra", div_ra_operand_o, as[w]);
    chk("issue_rb", div_rb_operand_o, bs[w]);
    cyc();
    flush_i = (mode == 1) ? (w ? 2'b10 : 2'b01) : (mode == 4) ? (w ? 2'b01 : 2'b10) : 2'b00;
    #1;
    chk("pulse_once", div_valid_o, 0);
    if (mode == 2) begin
      repeat (TO - 1) begin
        cyc();
        flush_i = '0;
      end
      #1;
      chk("timeout_early", resp_valid_o, 0);
      cyc();
    end else begin
      repeat (lat - 1) begin
        cyc();
        flush_i = '0;
      end
      div_wb_valid_i = 1'b1;
      div_wb_value_i = ref_div(div_opcode_o[14:12], div_ra_operand_o, div_rb_operand_o);
      cyc();
      div_wb_valid_i = 1'b0;
      flush_i = '0;
    end
    #1;
    if (mode == 1) begin
      chk("killed_no_resp", {resp_valid_o, busy_o}, 2'b00);
      return;
    end
    chk("resp_valid", resp_valid_o, 1);
    chk("resp_value", resp_value_o, exp_v);
    chk("resp_tag", {resp_id_o, resp_rd_idx_o, resp_timeout_o}, {w, rds[w], mode == 2});
    repeat (bp) begin
      cyc();
      req_valid_i = 2'b11;
      #1;
      chk("bp_hold", {resp_valid_o, resp_id_o, resp_rd_idx_o, req_ready_o}, {1'b1, w, rds[w], 2'b00});
      chk("bp_value", resp_value_o, exp_v);
    end
    cyc();
    req_valid_i = '0;
    resp_ready_i = (mode != 3);
    flush_i = (mode == 3) ? (w ? 2'b10 : 2'b01) : 2'b00;
    cyc();
    resp_ready_i = 1'b0;
    flush_i = '0;
    #1;
    chk("resp_done", {resp_valid_o, busy_o}, 2'b00);
  endtask
  initial begin
    logic [31:0] a, b;
    req_opcode_i = '0;
    req_pc_i = '0;
    req_rd_idx_i = '0;
    req_ra_operand_i = '0;
    req_rb_operand_i = '0;
    do_reset();
    chk("rst_ctrl", {req_ready_o, div_valid_o, resp_valid_o, resp_timeout_o, busy_o}, 0);
    chk("rst_regs", div_opcode_o | div_ra_operand_o | resp_value_o | div_pc_o, 0);
    set_req(0, 3'b101, 32'd100, 32'd7, 5'd5);
    set_req(1, 3'b101, 32'd1, 32'd1, 5'd1);
    run_txn(2'b01, 5, 0, 0);
    do_reset();
    for (int n = 0; n < 2; n++) set_req(n, 3'b111, 32'd17, 32'd5, 5'(n + 3));
    for (int i = 0; i < 4; i++) run_txn(2'b11, 3, 0, 0);
    set_req(0, 3'b110, 32'hFFFFFFF9, 32'h0, 5'd9);
    run_txn(2'b01, 2, 0, 0);
    repeat (3) begin
      cyc();
      div_wb_valid_i = 1'b1;
      div_wb_value_i = $urandom;
      #1;
      chk("spurious_wb", {resp_valid_o, busy_o}, 2'b00);
    end
    cyc();
    div_wb_valid_i = 1'b0;
    set_req(1, 3'b100, 32'd50, 32'd5, 5'd7);
    run_txn(2'b10, 6, 0, 1);
    set_req(0, 3'b101, 32'd9, 32'd3, 5'd2);
    run_txn(2'b01, 4, 0, 0);
    run_txn(2'b01, 1, 0, 2);
    run_txn(2'b01, 3, 5, 0);
    cyc();
    req_valid_i = 2'b01;
    flush_i = 2'b01;
    #1;
    chk("flush_blocks_grant", req_ready_o, 2'b00);
    req_valid_i = 2'b00;
    flush_i = 2'b00;
    set_req(1, 3'b101, 32'd77, 32'd0, 5'd4);
    cyc();
    req_valid_i = 2'b10;
    req_opcode_i = {ops[1], ops[0]};
    req_ra_operand_i = {as[1], as[0]};
    req_rb_operand_i = {bs[1], bs[0]};
    repeat (3) begin
      cyc();
      req_valid_i = '0;
    end
    #1;
    chk("pre_reset_busy", busy_o, 1);
    rst_i = 1'b1;
    cyc();
    #1;
    chk("reset_mid_ctrl", {req_ready_o, div_valid_o, resp_valid_o, resp_timeout_o, busy_o}, 0);
    chk("reset_mid_regs", div_opcode_o | div_ra_operand_o | div_rb_operand_o | resp_value_o, 0);
    rst_i = 1'b0;
    tb_last = 1'b1;
    div_wb_valid_i = 1'b1;
    div_wb_value_i = 32'd123;
    cyc();
    div_wb_valid_i = 1'b0;
    #1;
    chk("late_wb_ignored", {resp_valid_o, busy_o}, 2'b00);
    for (int i = 0; i < 60; i++) begin
      for (int n = 0; n < 2; n++) begin
        a = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
        case ($urandom_range(0, 5))
          0: b = 32'h0;
          1: b = 32'hFFFFFFFF;
          2: b = $urandom_range(1, 20);
          default: b = $urandom;
        endcase
        set_req(n, 3'(3'b100 + 3'($urandom_range(0, 3))), a, b, 5'($urandom));
      end
      case ($urandom_range(0, 4))
        0: run_txn(2'($urandom_range(1, 3)), $urandom_range(1, 12), $urandom_range(0, 3), 1);
        1: run_txn(2'($urandom_range(1, 3)), $urandom_range(1, 12), $urandom_range(0, 3), 3);
        2: run_txn(2'($urandom_range(1, 3)), $urandom_range(1, 12), $urandom_range(0, 3), 4);
        default: run_txn(2'($urandom_range(1, 3)), $urandom_range(1, 12), $urandom_range(0, 3), 0);
      endcase
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/riscv_base_div_sequencer.md
# riscv_base_div_sequencer

Controller that shares the single iterative `riscv_base_divider` between two requesters, for example two issue ports, or the main pipeline plus a debug/CSR path. It round-robin arbitrates incoming DIV/DIVU/REM/REMU requests and issues the winner to the divider as a one-cycle start. It waits for the divider's writeback, guarded by a timeout, and returns the result with the requester tag through a valid/ready response port. Per-requester flush discards in-flight work without aborting the divider.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 40: number of WAIT cycles without a divider writeback before a timeout response is forced.
- `TMR_W`, default 6: width of the timeout counter; must satisfy 2^TMR_W > TIMEOUT_CYCLES.

Ports:
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, synchronous and active-high.
- `req_valid_i` in 2: request valid, bit n belongs to requester n.
- `req_ready_o` out 2: request accepted; handshake completes when valid and ready are both high.
- `req_opcode_i` in 64: two 32-bit instruction words, requester n at bits [32n+31:32n].
- `req_pc_i` in 64: two 32-bit PCs, same packing.
- `req_rd_idx_i` in 10: two 5-bit destination register indices.
- `req_ra_operand_i` in 64: two 32-bit dividends.
- `req_rb_operand_i` in 64: two 32-bit divisors.
- `flush_i` in 2: kill any outstanding request belonging to requester n.
- `div_valid_o` out 1: start pulse to the divider.
- `div_opcode_o` out 32: captured instruction word.
- `div_pc_o` out 32: captured PC.
- `div_invalid_o` out 1: tied 0.
- `div_rd_idx_o`, `div_ra_idx_o`, `div_rb_idx_o` out 5 each: captured rd; ra from opcode[19:15]; rb from opcode[24:20].
- `div_ra_operand_o`, `div_rb_operand_o` out 32 each: captured operands.
- `div_wb_valid_i` in 1, `div_wb_value_i` in 32: divider writeback.
- `resp_valid_o` out 1: response valid.
- `resp_ready_i` in 1: response accepted.
- `resp_id_o` out 1: requester that owns the response.
- `resp_rd_idx_o` out 5: destination register of the response.
- `resp_value_o` out 32: result value.
- `resp_timeout_o` out 1: 1 when the response was forced by the timeout.
- `busy_o` out 1: 1 whenever the FSM is not in IDLE.

## Operation
- **FSM states:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - `req_ready_o[n]` is 1 only for the arbitration winner.
  - If both requesters are valid, the winner is the requester not granted last; if one is valid, it wins.
  - On handshake: capture opcode, pc, rd, ra and rb into the command registers; record id; update the last-grant pointer; clear kill; go to ISSUE.
- **ISSUE:** `div_valid_o` = 1 for exactly one cycle; clear the timer; go to WAIT.
- **WAIT:**
  - The timer increments every cycle.
  - On `div_wb_valid_i`:
    - If kill is set, go to IDLE with no response.
    - Otherwise capture `div_wb_value_i`, set `resp_timeout_o` = 0, and go to RESP.
  - Else, when timer == TIMEOUT_CYCLES-1:
    - If kill is set, go to IDLE.
    - Otherwise set value = 0 and `resp_timeout_o` = 1, and go to RESP.
- **RESP:**
  - `resp_valid_o` = 1, with all response fields held stable.
  - On `resp_ready_i`, go to IDLE.
  - If `flush_i[id]` is asserted, drop the response and go to IDLE the same cycle; this wins over `resp_ready_i`.
- **Divider writeback outside WAIT:** `div_wb_valid_i` is ignored in IDLE, ISSUE and RESP. The divider's divide-by-zero/overflow valid strobes may occur spuriously.
- **Flush in ISSUE or WAIT:** `flush_i[id]` sets kill. The divider is never aborted; the sequencer still waits for writeback or timeout before returning to IDLE.
- **Flush for the other requester, or in IDLE:** no effect. A flush in the same cycle as a handshake by that requester suppresses the grant, so `req_ready_o[n]` = 0.
- **Decoding:** the sequencer does no opcode decode. Upstream guarantees that only DIV/DIVU/REM/REMU requests are presented.

## Timing
- **Reset values:** state = IDLE. Last-grant pointer = 1, so requester 0 wins the first tie. `req_ready_o`, `div_valid_o`, `resp_valid_o`, `resp_timeout_o` and `busy_o` are 0. Command and response registers are 0.
- **Reset mid-operation:** returns to IDLE next edge. Any late divider writeback is then ignored in IDLE.
- **`req_ready_o`** is combinational from `req_valid_i`, `flush_i` and the pointer, and is valid only in IDLE. **All `div_*` outputs and all `resp_*` outputs** are registered.
- **Latency:** handshake in cycle T → `div_valid_o` in T+1 → divider result in T+1+L → `resp_valid_o` in T+2+L. The earliest next grant is the cycle after the response is accepted.
- **Throughput:** at most one request in flight.

## Structure
- **Package `riscv_base_div_seq_pkg`:** FSM state encoding, requester-id width, and the opcode field positions (rs1 [19:15], rs2 [24:20]).
- **Sub-module `riscv_base_rr_arb2`:** a 2-way round-robin arbiter with valid, enable and grant-update inputs.
- **Top level:** contains the FSM, command and response registers, kill flag, and timer.
- **Divider:** instantiated by the parent, not inside this block.

## Test plan
- **Single DIVU:** requester 0 issues DIVU 100/7 with rd = 5 → exactly one `div_valid_o` pulse. Response is value 14, id 0, rd 5, timeout 0.
- **Tie:** both requesters valid every cycle with REMU 17/5 → grants alternate 0,1,0,1. Every response value is 2.
- **Divide by zero:** REM with ra = 0xFFFFFFF9, rb = 0 → value 0xFFFFFFF9. Spurious writeback strobes in IDLE produce no response.
- **Flush:** `flush_i[1]` during WAIT of requester 1's DIV → no `resp_valid_o`, FSM returns to IDLE. The next requester 0 DIVU 9/3 returns 3.
- **Timeout:** stubbed divider never responds → `resp_valid_o` appears 40 cycles after WAIT entry with value 0 and `resp_timeout_o` = 1.
- **Backpressure and reset:** `resp_ready_i` held low 5 cycles → response held stable, `req_ready_o` stays 0. Reset asserted during WAIT → all outputs 0 next cycle and the FSM is in IDLE.
